// File: rtl/timer_irq_ctrl_pkg.sv
// Shared types and sizing helpers for the timer interrupt controller.
// Timer-subsystem glue uses irq_id_w() to size source-ID buses.
package timer_irq_ctrl_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } irq_state_t;

  localparam int DEF_NUM_SRC = 5;

  // Smallest ID width that can index n sources (minimum 1 bit).
  function automatic int irq_id_w(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

  localparam int DEF_ID_W = irq_id_w(DEF_NUM_SRC);

endpackage

// File: rtl/timer_irq_ctrl_if.sv
// Request/acknowledge handshake between the interrupt controller and its consumer.
interface timer_irq_ctrl_if #(
  parameter int ID_W = 3
);
  logic            irq_req;
  logic [ID_W-1:0] irq_id;
  logic            irq_ack;

  modport master (output irq_req, output irq_id, input irq_ack);
  modport slave  (input irq_req, input irq_id, output irq_ack);
endinterface

// File: rtl/timer_irq_ctrl_prio_enc.sv
// Lowest-index-first priority encoder with a valid flag; purely combinational.
module irq_prio_enc #(
  parameter int NUM_SRC = 5,
  parameter int ID_W    = 3
) (
  input  logic [NUM_SRC-1:0] req,
  output logic [ID_W-1:0]    idx,
  output logic               vld
);
  // Scan high-to-low so the lowest set index writes last and wins.
  always_comb begin
    idx = '0;
    vld = 1'b0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx = ID_W'(i);
        vld = 1'b1;
      end
    end
  end
endmodule

// File: rtl/timer_irq_ctrl.sv
// Timer interrupt aggregator: edge detect, pending/overrun latching, mask,
// fixed priority and a single req/ack channel toward the CPU side.
module timer_irq_ctrl
  import timer_irq_ctrl_pkg::*;
#(
  parameter int NUM_SRC = 5,
  parameter int ID_W    = irq_id_w(NUM_SRC)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] src_irq,
  input  logic               mask_we,
  input  logic [NUM_SRC-1:0] mask_wdata,
  output logic [NUM_SRC-1:0] mask,
  output logic [NUM_SRC-1:0] pending,
  output logic [NUM_SRC-1:0] overrun,
  timer_irq_ctrl_if.master   irq
);

  irq_state_t         state;
  logic [NUM_SRC-1:0] src_d;
  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] eligible;
  logic [NUM_SRC-1:0] cur_sel;
  logic [NUM_SRC-1:0] ack_clr;
  logic [ID_W-1:0]    win_idx;
  logic               win_vld;
  logic               req_q;
  logic [ID_W-1:0]    id_q;
  logic               do_ack;
  logic               cur_masked;

  assign rise     = src_irq & ~src_d;
  assign eligible = pending & ~mask;

  // One-hot of the source currently being requested.
  always_comb begin
    cur_sel = '0;
    for (int i = 0; i < NUM_SRC; i++) cur_sel[i] = (ID_W'(i) == id_q);
  end

  assign do_ack     = (state == REQ) && irq.irq_ack;
  assign ack_clr    = do_ack ? cur_sel : '0;
  assign cur_masked = |(mask & cur_sel);

  irq_prio_enc #(
    .NUM_SRC (NUM_SRC),
    .ID_W    (ID_W)
  ) u_prio (
    .req (eligible),
    .idx (win_idx),
    .vld (win_vld)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      src_d   <= '0;
      pending <= '0;
      overrun <= '0;
      mask    <= '1;
    end else begin
      src_d   <= src_irq;
      // A rise coinciding with its own ack re-arms pending but is not an overrun.
      pending <= (pending & ~ack_clr) | rise;
      overrun <= (overrun & ~ack_clr) | (rise & pending & ~ack_clr);
      if (mask_we) mask <= mask_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      req_q <= 1'b0;
      id_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_vld) begin
            id_q  <= win_idx;
            req_q <= 1'b1;
            state <= REQ;
          end
        end
        REQ: begin
          // Ack takes precedence over a withdraw caused by masking.
          if (irq.irq_ack || cur_masked) begin
            req_q <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          req_q <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign irq.irq_req = req_q;
  assign irq.irq_id  = id_q;

endmodule

// File: tb/tb_timer_irq_ctrl.sv
// Directed bench for timer_irq_ctrl; expected values are hand-derived.
module tb_timer_irq_ctrl;

  localparam int NUM_SRC = 5;
  localparam int ID_W    = 3;

  logic               clk;
  logic               rst;
  logic [NUM_SRC-1:0] src_irq;
  logic               mask_we;
  logic [NUM_SRC-1:0] mask_wdata;
  logic [NUM_SRC-1:0] mask;
  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] overrun;

  int n_pass = 0;
  int n_tot  = 0;

  timer_irq_ctrl_if #(.ID_W(ID_W)) irq_if ();

  timer_irq_ctrl #(
    .NUM_SRC (NUM_SRC),
    .ID_W    (ID_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .src_irq    (src_irq),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .mask       (mask),
    .pending    (pending),
    .overrun    (overrun),
    .irq        (irq_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic wr_mask(input logic [NUM_SRC-1:0] v);
    mask_we    = 1'b1;
    mask_wdata = v;
    tick();
    mask_we    = 1'b0;
  endtask

  task automatic pulse(input logic [NUM_SRC-1:0] v);
    src_irq = v;
    tick();
    src_irq = '0;
  endtask

  task automatic ack();
    irq_if.irq_ack = 1'b1;
    tick();
    irq_if.irq_ack = 1'b0;
  endtask

  initial begin
    rst = 1'b0; src_irq = '0; mask_we = 1'b0; mask_wdata = '0; irq_if.irq_ack = 1'b0;
    tick(); tick();
    chk("rst_mask", 32'(mask), 32'h1f);
    chk("rst_pend", 32'(pending), 32'h0);
    chk("rst_ovr",  32'(overrun), 32'h0);
    chk("rst_req",  32'(irq_if.irq_req), 32'h0);
    chk("rst_id",   32'(irq_if.irq_id), 32'h0);
    rst = 1'b1;
    tick();

    // Single pulse on source 2, two-cycle latency
    wr_mask(5'b00000);
    pulse(5'b00100);
    chk("t1_pend", 32'(pending), 32'h04);
    chk("t1_req0", 32'(irq_if.irq_req), 32'h0);
    tick();
    chk("t1_req", 32'(irq_if.irq_req), 32'h1);
    chk("t1_id",  32'(irq_if.irq_id), 32'h2);
    ack();
    chk("t1_pend_clr", 32'(pending), 32'h0);
    chk("t1_req_clr",  32'(irq_if.irq_req), 32'h0);

    // Simultaneous sources 1 and 3: priority then idle gap
    pulse(5'b01010);
    tick();
    chk("t2_id1", 32'(irq_if.irq_id), 32'h1);
    ack();
    chk("t2_gap",  32'(irq_if.irq_req), 32'h0);
    chk("t2_pend", 32'(pending), 32'h08);
    tick();
    chk("t2_req3", 32'(irq_if.irq_req), 32'h1);
    chk("t2_id3",  32'(irq_if.irq_id), 32'h3);
    ack();
    chk("t2_done", 32'(pending), 32'h0);

    // Masked pending, then unmask
    wr_mask(5'b11111);
    pulse(5'b00001);
    tick(); tick();
    chk("t3_pend",   32'(pending), 32'h01);
    chk("t3_masked", 32'(irq_if.irq_req), 32'h0);
    wr_mask(5'b00000);
    chk("t3_req_wait", 32'(irq_if.irq_req), 32'h0);
    tick();
    chk("t3_req", 32'(irq_if.irq_req), 32'h1);
    chk("t3_id",  32'(irq_if.irq_id), 32'h0);
    ack();
    chk("t3_done", 32'(pending), 32'h0);

    // ID frozen in REQ despite higher-priority arrival
    pulse(5'b10000);
    tick();
    chk("t4_id4", 32'(irq_if.irq_id), 32'h4);
    pulse(5'b00001);
    tick();
    chk("t4_frozen", 32'(irq_if.irq_id), 32'h4);
    chk("t4_pend",   32'(pending), 32'h11);
    ack();
    chk("t4_gap", 32'(irq_if.irq_req), 32'h0);
    tick();
    chk("t4_req0", 32'(irq_if.irq_req), 32'h1);
    chk("t4_id0",  32'(irq_if.irq_id), 32'h0);
    ack();

    // Overrun set, cleared by ack, and rise coinciding with ack
    pulse(5'b00010);
    tick();
    chk("t5_id1", 32'(irq_if.irq_id), 32'h1);
    pulse(5'b00010);
    chk("t5_ovr",  32'(overrun), 32'h02);
    chk("t5_pend", 32'(pending), 32'h02);
    ack();
    chk("t5_ovr_clr",  32'(overrun), 32'h0);
    chk("t5_pend_clr", 32'(pending), 32'h0);
    pulse(5'b00010);
    tick();
    chk("t5_req_again", 32'(irq_if.irq_req), 32'h1);
    src_irq = 5'b00010; irq_if.irq_ack = 1'b1;
    tick();
    src_irq = '0; irq_if.irq_ack = 1'b0;
    chk("t5_race_pend", 32'(pending), 32'h02);
    chk("t5_race_ovr",  32'(overrun), 32'h0);
    chk("t5_race_req",  32'(irq_if.irq_req), 32'h0);
    tick();
    chk("t5_rereq", 32'(irq_if.irq_req), 32'h1);
    chk("t5_reid",  32'(irq_if.irq_id), 32'h1);

    // Masking the requested source withdraws it, pending kept
    wr_mask(5'b00010);
    tick();
    chk("t6_withdraw", 32'(irq_if.irq_req), 32'h0);
    chk("t6_kept",     32'(pending), 32'h02);

    // Async reset mid-REQ
    wr_mask(5'b00000);
    tick();
    chk("t7_req", 32'(irq_if.irq_req), 32'h1);
    #2 rst = 1'b0;
    #1;
    chk("t7_rst_req",  32'(irq_if.irq_req), 32'h0);
    chk("t7_rst_pend", 32'(pending), 32'h0);
    chk("t7_rst_mask", 32'(mask), 32'h1f);
    tick();
    rst = 1'b1;
    tick(); tick(); tick();
    chk("t7_quiet", 32'(irq_if.irq_req), 32'h0);
    pulse(5'b01000);
    wr_mask(5'b00000);
    tick();
    chk("t7_new_req", 32'(irq_if.irq_req), 32'h1);
    chk("t7_new_id",  32'(irq_if.irq_id), 32'h3);
    ack();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
